// File: rtl/gg_bit_unpack.sv
// Bit-stream unpacker: buffers two 512-bit memory words and exposes an MSB-first
// peek window with variable-length advance, byte alignment and startcode tagging.
module gg_bit_unpack #(
  parameter int unsigned WIN_LEN   = 32,
  parameter int unsigned BUF_WORDS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [511:0]       mem_word,
  input  logic [63:0]        mem_startcode,
  input  logic               mem_valid,
  output logic               mem_ready,
  output logic [WIN_LEN-1:0] bits_window,
  output logic [10:0]        bits_avail,
  output logic               win_valid,
  output logic               win_startcode,
  output logic               byte_aligned,
  input  logic               advance,
  input  logic [5:0]         advance_len,
  input  logic               align,
  output logic               err
);

  localparam logic [5:0] MaxAdv   = 6'(WIN_LEN);
  localparam logic [1:0] MaxWords = 2'(BUF_WORDS);

  logic [511:0] w0_q, w0_d, w1_q, w1_d;
  logic [63:0]  sc0_q, sc0_d, sc1_q, sc1_d;
  logic [1:0]   nwords_q, nwords_d;
  logic [8:0]   off_q, off_d;
  logic         err_q, err_d;

  logic [1023:0]       cat_raw, cat_str;
  logic [WIN_LEN-1:0]  win_raw;
  logic [10:0]         limit, p;
  logic [1:0]          nw;
  logic                illegal, accept, drop;

  assign limit      = {nwords_q, 9'd0};
  assign bits_avail = limit - {2'd0, off_q};
  assign mem_ready  = (nwords_q < MaxWords) && !flush;
  assign win_valid  = bits_avail >= 11'(WIN_LEN);
  assign byte_aligned  = (off_q[2:0] == 3'd0);
  assign win_startcode = sc0_q[off_q[8:3]] && (nwords_q != 2'd0);
  assign err        = err_q;

  // Reorder so stream bit k sits at index k: bytes stay in place, bits within a byte flip.
  always_comb begin
    cat_raw = {w1_q, w0_q};
    for (int k = 0; k < 1024; k++) begin
      cat_str[k] = cat_raw[{k[9:3], ~k[2:0]}];
    end
    win_raw = cat_str[{1'b0, off_q} +: WIN_LEN];
    for (int j = 0; j < int'(WIN_LEN); j++) begin
      bits_window[WIN_LEN-1-j] = win_raw[j] && (j < int'(bits_avail));
    end
  end

  always_comb begin
    w0_d     = w0_q;
    w1_d     = w1_q;
    sc0_d    = sc0_q;
    sc1_d    = sc1_q;
    err_d    = err_q;
    illegal  = advance && ((advance_len > MaxAdv) || ({5'd0, advance_len} > bits_avail));
    accept   = mem_valid && mem_ready;
    p        = {2'd0, off_q};
    if (advance && !illegal) begin
      p = p + {5'd0, advance_len};
      if (align) begin
        p = (p + 11'd7) & ~11'd7;
        if (p > limit) p = limit;
      end
    end
    drop = (p >= 11'd512);
    nw   = nwords_q;
    if (illegal) err_d = 1'b1;
    if (drop) begin
      w0_d  = w1_q;
      sc0_d = sc1_q;
      w1_d  = '0;
      sc1_d = '0;
      nw    = nwords_q - 2'd1;
    end
    // p < 1024, so after a drop the low nine bits are exactly p - 512.
    off_d = p[8:0];
    if (accept) begin
      if (nw == 2'd0) begin
        w0_d  = mem_word;
        sc0_d = mem_startcode;
      end else begin
        w1_d  = mem_word;
        sc1_d = mem_startcode;
      end
      nw = nw + 2'd1;
    end
    nwords_d = nw;
    if (flush) begin
      w0_d     = '0;
      w1_d     = '0;
      sc0_d    = '0;
      sc1_d    = '0;
      nwords_d = '0;
      off_d    = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w0_q     <= '0;
      w1_q     <= '0;
      sc0_q    <= '0;
      sc1_q    <= '0;
      nwords_q <= '0;
      off_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      sc0_q    <= sc0_d;
      sc1_q    <= sc1_d;
      nwords_q <= nwords_d;
      off_q    <= off_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_gg_bit_unpack.sv
// Self-checking bench for gg_bit_unpack: directed scenarios followed by random traffic,
// compared against a word-queue model of the stream.
module tb_gg_bit_unpack;

  logic         clk = 1'b0;
  logic         reset, flush, mem_valid, mem_ready, win_valid, win_startcode;
  logic         byte_aligned, advance, align, err;
  logic [511:0] mem_word;
  logic [63:0]  mem_startcode;
  logic [31:0]  bits_window;
  logic [10:0]  bits_avail;
  logic [5:0]   advance_len;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of raw words in arrival order plus read offset into the head.
  logic [511:0] mq[$];
  logic [63:0]  msc[$];
  int           moff;
  bit           merr;

  gg_bit_unpack #(.WIN_LEN(32), .BUF_WORDS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .mem_word      (mem_word),
    .mem_startcode (mem_startcode),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .bits_window   (bits_window),
    .bits_avail    (bits_avail),
    .win_valid     (win_valid),
    .win_startcode (win_startcode),
    .byte_aligned  (byte_aligned),
    .advance       (advance),
    .advance_len   (advance_len),
    .align         (align),
    .err           (err)
  );

  always #5 clk = ~clk;

  function automatic int m_avail();
    return mq.size() * 512 - moff;
  endfunction

  function automatic logic [31:0] m_window();
    logic [31:0] r = '0;
    int pos, wi, b;
    for (int j = 0; j < 32; j++) begin
      pos = moff + j;
      if (pos < mq.size() * 512) begin
        wi = pos / 512;
        b  = pos % 512;
        r[31-j] = mq[wi][8 * (b / 8) + 7 - (b % 8)];
      end
    end
    return r;
  endfunction

  function automatic logic m_sc();
    if (mq.size() == 0) return 1'b0;
    return msc[0][moff / 8];
  endfunction

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic m_clear();
    mq.delete();
    msc.delete();
    moff = 0;
    merr = 1'b0;
  endtask

  task automatic m_update(input bit mv, input logic [511:0] w, input logic [63:0] sc,
                          input bit adv, input int len, input bit al, input bit fl);
    bit acc;
    int p, av;
    if (fl) begin
      m_clear();
      return;
    end
    acc = mv && (mq.size() < 2);
    av  = m_avail();
    if (adv) begin
      if (len > 32 || len > av) begin
        merr = 1'b1;
      end else begin
        p = moff + len;
        if (al) begin
          p = ((p + 7) / 8) * 8;
          if (p > mq.size() * 512) p = mq.size() * 512;
        end
        if (p >= 512) begin
          void'(mq.pop_front());
          void'(msc.pop_front());
          p = p - 512;
        end
        moff = p;
      end
    end
    if (acc) begin
      mq.push_back(w);
      msc.push_back(sc);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".window"}, 64'(bits_window), 64'(m_window()));
    chk({tag, ".avail"}, 64'(bits_avail), 64'(m_avail()));
    chk({tag, ".win_valid"}, 64'(win_valid), 64'(m_avail() >= 32));
    chk({tag, ".startcode"}, 64'(win_startcode), 64'(m_sc()));
    chk({tag, ".aligned"}, 64'(byte_aligned), 64'(moff % 8 == 0));
    chk({tag, ".err"}, 64'(err), 64'(merr));
    chk({tag, ".ready"}, 64'(mem_ready), 64'(mq.size() < 2 && !flush));
  endtask

  task automatic step(input bit mv, input logic [511:0] w, input logic [63:0] sc,
                      input bit adv, input int len, input bit al, input bit fl,
                      input string tag);
    mem_valid     = mv;
    mem_word      = w;
    mem_startcode = sc;
    advance       = adv;
    advance_len   = 6'(len);
    align         = al;
    flush         = fl;
    #1;
    chk({tag, ".ready_pre"}, 64'(mem_ready), 64'(mq.size() < 2 && !fl));
    @(posedge clk);
    m_update(mv, w, sc, adv, len, al, fl);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic adv(input int len, input bit al, input string tag);
    step(1'b0, '0, '0, 1'b1, len, al, 1'b0, tag);
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_word = '0; mem_startcode = '0;
    advance = 1'b0; advance_len = '0; align = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [511:0] wa, wb, wc, wd;
    int len, av;
    bit fl;
    idle_inputs();
    m_clear();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.ready_const", 64'(mem_ready), 64'd1);
    reset = 1'b0;

    // First word: window is the first four bytes, MSB first.
    wa = rand_word();
    wa[31:0] = 32'h01FF3CA5;
    step(1'b1, wa, '0, 1'b0, 0, 1'b0, 1'b0, "word1");
    chk("word1.const_window", 64'(bits_window), 64'h0000_0000_A53C_FF01);
    chk("word1.const_avail", 64'(bits_avail), 64'd512);

    wb = rand_word();
    step(1'b1, wb, 64'h6, 1'b0, 0, 1'b0, 1'b0, "word2");
    for (int i = 0; i < 15; i++) adv(32, 1'b0, "walk480");
    adv(20, 1'b0, "to500");
    adv(20, 1'b0, "straddle_drop");
    chk("straddle.const_avail", 64'(bits_avail), 64'd504);
    chk("straddle.const_sc", 64'(win_startcode), 64'd1);
    adv(3, 1'b1, "align16");
    chk("align16.const_aligned", 64'(byte_aligned), 64'd1);
    chk("align16.const_sc", 64'(win_startcode), 64'd1);
    adv(8, 1'b0, "off24");

    for (int i = 0; i < 14; i++) adv(32, 1'b0, "walk472");
    adv(8, 1'b0, "off480");
    wc = rand_word();
    step(1'b1, wc, '0, 1'b1, 32, 1'b0, 1'b0, "drop_accept");
    chk("drop_accept.const_avail", 64'(bits_avail), 64'd512);

    adv(40, 1'b0, "illegal40");
    chk("illegal40.const_err", 64'(err), 64'd1);
    for (int i = 0; i < 15; i++) adv(32, 1'b0, "walk480b");
    adv(22, 1'b0, "off502");
    adv(20, 1'b0, "illegal20");
    chk("illegal20.const_avail", 64'(bits_avail), 64'd10);
    wd = rand_word();
    step(1'b1, wd, '1, 1'b1, 4, 1'b1, 1'b1, "flush");
    chk("flush.const_err", 64'(err), 64'd0);
    step(1'b0, '0, '0, 1'b0, 0, 1'b0, 1'b0, "post_flush");
    chk("post_flush.const_avail", 64'(bits_avail), 64'd0);

    for (int i = 0; i < 400; i++) begin
      av  = m_avail();
      len = $urandom_range(0, 32);
      if (len > av && $urandom_range(0, 19) != 0) len = av;
      if ($urandom_range(0, 49) == 0) len = $urandom_range(33, 40);
      fl = ($urandom_range(0, 49) == 0);
      step(1'($urandom_range(0, 1)), rand_word(), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), len, ($urandom_range(0, 3) == 0), fl, "rand");
    end

    // Asynchronous reset in the middle of a cycle.
    step(1'b1, rand_word(), '0, 1'b0, 0, 1'b0, 1'b0, "pre_reset");
    idle_inputs();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    m_clear();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, rand_word(), 64'h1, 1'b0, 0, 1'b0, 1'b0, "after_reset");
    chk("after_reset.const_avail", 64'(bits_avail), 64'd512);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
